// File: rtl/ascon_state_serializer.sv
`default_nettype none
// ============================================================================
// Module   : ascon_state_serializer
// Brief    : Bit-slices IV/key/nonce into the bit-serial Ascon permutation and
//            streams round constants MSB-first from an independent engine.
// Revision : 1.0 - initial release
// ============================================================================
module ascon_state_serializer #(
   parameter int PB_OFFSET = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [1:0]   load_sel,
   input  logic [63:0]  iv,
   input  logic [127:0] key,
   input  logic [127:0] nonce,
   output logic [4:0]   serial_data,
   output logic         serial_valid,
   output logic         busy,
   output logic         done,
   input  logic         const_start,
   input  logic         const_mode,
   input  logic [3:0]   round_idx,
   output logic         const_bit,
   output logic         const_valid,
   output logic         const_err
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   localparam logic [5:0] c_last_slice = 6'd63;
   localparam logic [5:0] c_max_k      = 6'd11;

   state_t       r_state;
   logic [5:0]   r_cnt;
   logic [63:0]  r_iv;
   logic [127:0] r_key;
   logic [127:0] r_nonce;
   logic [1:0]   r_sel;

   logic [7:0]   r_cshift;
   logic [2:0]   r_crem;

   logic [5:0]   w_k;
   logic [7:0]   w_cbyte;

   assign w_k     = {2'b00, round_idx} + (const_mode ? 6'(PB_OFFSET) : 6'd0);
   assign w_cbyte = {4'd15 - w_k[3:0], w_k[3:0]};

   // Slice i takes bit (63-i) of every 64-bit lane, with unloaded lanes masked.
   function automatic logic [4:0] slice_of(
      input logic [63:0]  f_iv,
      input logic [127:0] f_key,
      input logic [127:0] f_nonce,
      input logic [1:0]   f_sel,
      input logic [5:0]   f_i
   );
      logic [4:0] raw;
      logic [4:0] mask;
      raw = {f_iv[6'd63 - f_i],
             f_key[7'd127 - {1'b0, f_i}],
             f_key[7'd63 - {1'b0, f_i}],
             f_nonce[7'd127 - {1'b0, f_i}],
             f_nonce[7'd63 - {1'b0, f_i}]};
      case (f_sel)
         2'd0:    mask = 5'b11111;
         2'd1:    mask = 5'b01000;
         2'd2:    mask = 5'b00100;
         default: mask = 5'b01100;
      endcase
      return raw & mask;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_cnt        <= 6'd0;
         r_iv         <= 64'd0;
         r_key        <= 128'd0;
         r_nonce      <= 128'd0;
         r_sel        <= 2'd0;
         serial_data  <= 5'd0;
         serial_valid <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_iv         <= iv;
                  r_key        <= key;
                  r_nonce      <= nonce;
                  r_sel        <= load_sel;
                  r_cnt        <= 6'd0;
                  r_state      <= ST_SHIFT;
                  serial_data  <= slice_of(iv, key, nonce, load_sel, 6'd0);
                  serial_valid <= 1'b1;
                  busy         <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (r_cnt == c_last_slice) begin
                  r_state      <= ST_IDLE;
                  r_cnt        <= 6'd0;
                  serial_data  <= 5'd0;
                  serial_valid <= 1'b0;
                  busy         <= 1'b0;
                  done         <= 1'b1;
               end else begin
                  r_cnt       <= r_cnt + 6'd1;
                  serial_data <= slice_of(r_iv, r_key, r_nonce, r_sel, r_cnt + 6'd1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Constant engine: const_valid doubles as its busy flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cshift    <= 8'd0;
         r_crem      <= 3'd0;
         const_bit   <= 1'b0;
         const_valid <= 1'b0;
         const_err   <= 1'b0;
      end else begin
         const_err <= 1'b0;
         if (const_valid) begin
            if (r_crem == 3'd0) begin
               const_valid <= 1'b0;
               const_bit   <= 1'b0;
            end else begin
               const_bit <= r_cshift[7];
               r_cshift  <= {r_cshift[6:0], 1'b0};
               r_crem    <= r_crem - 3'd1;
            end
         end else if (const_start) begin
            if (w_k <= c_max_k) begin
               const_bit   <= w_cbyte[7];
               const_valid <= 1'b1;
               r_cshift    <= {w_cbyte[6:0], 1'b0};
               r_crem      <= 3'd7;
            end else begin
               const_err <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ascon_state_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ascon_state_serializer
// Brief    : Directed and randomized bench with a lane/queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ascon_state_serializer;

   localparam int c_pb_offset = 6;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   load_sel = 2'd0;
   logic [63:0]  iv = 64'd0;
   logic [127:0] key = 128'd0;
   logic [127:0] nonce = 128'd0;
   logic         const_start = 1'b0;
   logic         const_mode = 1'b0;
   logic [3:0]   round_idx = 4'd0;
   logic [4:0]   serial_data;
   logic         serial_valid, busy, done, const_bit, const_valid, const_err;

   int checks = 0;
   int failures = 0;

   ascon_state_serializer #(.PB_OFFSET(c_pb_offset)) dut (
      .clk(clk), .rst(rst), .start(start), .load_sel(load_sel),
      .iv(iv), .key(key), .nonce(nonce),
      .serial_data(serial_data), .serial_valid(serial_valid),
      .busy(busy), .done(done),
      .const_start(const_start), .const_mode(const_mode), .round_idx(round_idx),
      .const_bit(const_bit), .const_valid(const_valid), .const_err(const_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pos is the slice index on the output (-1 when idle),
   // cq holds the constant bits still to appear, front first.
   int         pos = -1;
   logic [63:0] lane [5];
   bit         cq[$];
   logic       e_done = 1'b0;
   logic       e_err = 1'b0;
   bit         model_ok = 1'b0;

   always @(posedge clk) begin
      int k;
      logic [7:0] cb;
      model_ok = 1'b1;
      if (!rst) begin
         pos = -1;
         cq.delete();
         e_done = 1'b0;
         e_err = 1'b0;
      end else begin
         e_done = 1'b0;
         e_err = 1'b0;
         if (pos < 0) begin
            if (start) begin
               lane[0] = (load_sel == 2'd0) ? iv : 64'd0;
               lane[1] = (load_sel != 2'd2) ? key[127:64] : 64'd0;
               lane[2] = (load_sel != 2'd1) ? key[63:0] : 64'd0;
               lane[3] = (load_sel == 2'd0) ? nonce[127:64] : 64'd0;
               lane[4] = (load_sel == 2'd0) ? nonce[63:0] : 64'd0;
               pos = 0;
            end
         end else if (pos == 63) begin
            pos = -1;
            e_done = 1'b1;
         end else begin
            pos++;
         end
         if (cq.size() > 0) begin
            void'(cq.pop_front());
         end else if (const_start) begin
            k = int'(round_idx) + (const_mode ? c_pb_offset : 0);
            if (k <= 11) begin
               cb = {4'(15 - k), 4'(k)};
               for (int b = 7; b >= 0; b--) cq.push_back(cb[b]);
            end else begin
               e_err = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [4:0] es;
      if (model_ok) begin
         es = 5'd0;
         if (pos >= 0)
            for (int l = 0; l < 5; l++) es[4 - l] = lane[l][63 - pos];
         check("outputs",
               {19'd0, serial_data, serial_valid, busy, done, const_bit, const_valid, const_err},
               {19'd0, es, pos >= 0, pos >= 0, e_done,
                (cq.size() > 0) ? cq[0] : 1'b0, cq.size() > 0, e_err});
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic const_byte(input logic m, input logic [3:0] ri, input logic [7:0] exp, input string nm);
      logic [7:0] b;
      int vc;
      b = 8'd0;
      vc = 0;
      const_mode = m; round_idx = ri; const_start = 1'b1;
      tick();
      const_start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         b = {b[6:0], const_bit};
         vc += int'(const_valid);
         tick();
      end
      check({nm, "_byte"}, {24'd0, b}, {24'd0, exp});
      check({nm, "_vcount"}, vc, 8);
      check({nm, "_after"}, {30'd0, const_valid, const_bit}, 32'd0);
   endtask

   initial begin
      int n;
      int dcount;
      repeat (3) tick();
      check("reset_outputs",
            {20'd0, serial_data, serial_valid, busy, done, const_bit, const_valid, const_err}, 32'd0);
      rst = 1'b1;
      tick();

      // Full init burst with known operands
      iv = 64'h80400C0600000000;
      key = 128'h00000000_12153524_00000000_12153524;
      nonce = 128'hFFFFFFFF_C0895E81_FFFFFFFF_C0895E81;
      load_sel = 2'd0; start = 1'b1;
      tick();
      start = 1'b0;
      check("slice0", {27'd0, serial_data}, {27'd0, 5'b10011});
      check("busy_slice0", {31'd0, busy}, 32'd1);
      repeat (63) tick();
      check("slice63", {27'd0, serial_data}, {27'd0, 5'b00011});
      tick();
      check("done_pulse", {29'd0, done, serial_valid, busy}, {29'd0, 3'b100});
      tick();
      check("done_single", {31'd0, done}, 32'd0);

      // Key-hi only
      load_sel = 2'd1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 64; i++) begin
         check("sel1_slice", {27'd0, serial_data}, {27'd0, 1'b0, key[127 - i], 3'b000});
         tick();
      end
      tick();

      // Constant engine
      const_byte(1'b0, 4'd1, 8'hE1, "pa_r1");
      const_byte(1'b1, 4'd0, 8'h96, "pb_r0");
      const_byte(1'b0, 4'd0, 8'hF0, "pa_r0");
      const_byte(1'b0, 4'd11, 8'h4B, "pa_r11");
      const_mode = 1'b1; round_idx = 4'd6; const_start = 1'b1;
      tick();
      const_start = 1'b0;
      check("pb_r6_err", {30'd0, const_err, const_valid}, {30'd0, 2'b10});
      tick();
      check("pb_r6_err_once", {30'd0, const_err, const_valid}, 32'd0);

      // Start while busy ignored, start in done cycle accepted
      load_sel = 2'd0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (20) tick();
      iv = 64'hDEADBEEF_01234567; start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!done && n < 100) begin tick(); n++; end
      check("done_seen", {31'd0, done}, 32'd1);
      check("ignored_start_len", n, 43);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("restart_on_done", {30'd0, serial_valid, busy}, {30'd0, 2'b11});
      repeat (70) tick();

      // Reset mid-burst
      iv = 64'h0123456789ABCDEF; start = 1'b1;
      tick();
      start = 1'b0;
      const_mode = 1'b0; round_idx = 4'd2; const_start = 1'b1;
      repeat (30) begin tick(); const_start = 1'b0; end
      rst = 1'b0;
      tick();
      check("mid_reset",
            {20'd0, serial_data, serial_valid, busy, done, const_bit, const_valid, const_err}, 32'd0);
      rst = 1'b1;
      dcount = 0;
      for (int i = 0; i < 70; i++) begin
         dcount += int'(done) + int'(serial_valid) + int'(busy);
         tick();
      end
      check("no_resume", dcount, 0);

      // Randomized traffic, both engines concurrently
      for (int c = 0; c < 4000; c++) begin
         rst = ($urandom_range(0, 299) != 0);
         start = ($urandom_range(0, 15) == 0);
         load_sel = 2'($urandom_range(0, 3));
         iv = {$urandom, $urandom};
         key = {$urandom, $urandom, $urandom, $urandom};
         nonce = {$urandom, $urandom, $urandom, $urandom};
         const_start = ($urandom_range(0, 3) == 0);
         const_mode = 1'($urandom_range(0, 1));
         round_idx = 4'($urandom_range(0, 15));
         tick();
      end
      start = 1'b0; const_start = 1'b0;
      repeat (80) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
